// File: rtl/dmac_wr_engine.sv
// DMAC write engine: drains the show-ahead FIFO into AXI INCR write bursts,
// one burst outstanding at a time, never crossing a 4 KB boundary.
//   state  | meaning
//   S_IDLE | waiting for start, done_o high
//   S_AW   | presenting the burst address
//   S_W    | streaming burst beats from the FIFO
//   S_B    | waiting for the write response
module dmac_wr_engine #(
  parameter int          MAX_BURST_LG2 = 4,
  parameter logic [3:0]  ID            = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] dst_addr_i,
  input  logic [15:0] byte_len_i,
  output logic        done_o,
  output logic        err_o,
  input  logic        fifo_empty_i,
  input  logic [31:0] fifo_rdata_i,
  output logic        fifo_rden_o,
  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic [3:0]  awlen_o,
  output logic [2:0]  awsize_o,
  output logic [1:0]  awburst_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [3:0]  wid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  localparam logic [15:0] MAX_BEATS = 16'(1 << MAX_BURST_LG2);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_addr;
  logic [15:0] r_remain;
  logic [3:0]  r_beat_cnt;
  logic [4:0]  r_burst_len;
  logic        r_err;

  logic [10:0] w_to_4k_words;
  logic [15:0] w_cap;
  logic [4:0]  w_burst_len;
  logic [15:0] w_remain_nxt;
  logic        w_start_ok;
  logic        w_wvalid;
  logic        w_whs;

  // Address LSBs, length LSBs and BID carry no information for this engine.
  logic w_unused;
  assign w_unused = ^{bid_i, dst_addr_i[1:0], byte_len_i[1:0]};

  always_comb begin
    w_to_4k_words = 11'h400 - {1'b0, r_addr[11:2]};
    w_cap = (r_remain < MAX_BEATS) ? r_remain : MAX_BEATS;
    if ({5'd0, w_to_4k_words} < w_cap)
      w_cap = {5'd0, w_to_4k_words};
    w_burst_len = w_cap[4:0];
  end

  assign w_remain_nxt = r_remain - {11'd0, r_burst_len};
  assign w_start_ok   = start_i && (byte_len_i[15:2] != 14'd0);
  assign w_wvalid     = (r_state == S_W) && !fifo_empty_i;
  assign w_whs        = w_wvalid && wready_i;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_state_nxt = S_AW;
      S_AW:   if (awready_i) w_state_nxt = S_W;
      S_W:    if (w_whs && r_beat_cnt == 4'd0) w_state_nxt = S_B;
      S_B:    if (bvalid_i) w_state_nxt = (w_remain_nxt == 16'd0) ? S_IDLE : S_AW;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= 32'd0;
      r_remain    <= 16'd0;
      r_beat_cnt  <= 4'd0;
      r_burst_len <= 5'd0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start_ok) begin
          r_addr   <= {dst_addr_i[31:2], 2'b00};
          r_remain <= {2'b00, byte_len_i[15:2]};
          r_err    <= 1'b0;
        end
        S_AW: if (awready_i) begin
          r_beat_cnt  <= w_burst_len[3:0] - 4'd1;
          r_burst_len <= w_burst_len;
        end
        S_W: if (w_whs) r_beat_cnt <= r_beat_cnt - 4'd1;
        S_B: if (bvalid_i) begin
          r_err    <= r_err | (bresp_i != 2'b00);
          r_addr   <= r_addr + {25'd0, r_burst_len, 2'b00};
          r_remain <= w_remain_nxt;
        end
        default: ;
      endcase
    end
  end

  assign done_o      = (r_state == S_IDLE);
  assign err_o       = r_err;
  assign awid_o      = ID;
  assign awaddr_o    = (r_state == S_AW) ? r_addr : 32'd0;
  assign awlen_o     = (r_state == S_AW) ? (w_burst_len[3:0] - 4'd1) : 4'd0;
  assign awsize_o    = 3'b010;
  assign awburst_o   = 2'b01;
  assign awvalid_o   = (r_state == S_AW);
  assign wid_o       = ID;
  assign wdata_o     = fifo_rdata_i;
  assign wstrb_o     = 4'hF;
  assign wlast_o     = (r_state == S_W) && (r_beat_cnt == 4'd0);
  assign wvalid_o    = w_wvalid;
  assign fifo_rden_o = w_whs;
  assign bready_o    = (r_state == S_B);

endmodule

// File: tb/tb_dmac_wr_engine.sv
// Bench for dmac_wr_engine: FIFO and AXI slave models with AW and W
// scoreboards fed when a command is set up.
module tb_dmac_wr_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] dst_addr_i;
  logic [15:0] byte_len_i;
  logic        done_o, err_o;
  logic        fifo_empty_i;
  logic [31:0] fifo_rdata_i;
  logic        fifo_rden_o;
  logic [3:0]  awid_o;
  logic [31:0] awaddr_o;
  logic [3:0]  awlen_o;
  logic [2:0]  awsize_o;
  logic [1:0]  awburst_o;
  logic        awvalid_o, awready_i;
  logic [3:0]  wid_o;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wlast_o, wvalid_o, wready_i;
  logic [3:0]  bid_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i, bready_o;

  dmac_wr_engine dut (
    .clk(clk), .rst(rst), .start_i(start_i), .dst_addr_i(dst_addr_i),
    .byte_len_i(byte_len_i), .done_o(done_o), .err_o(err_o),
    .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i), .fifo_rden_o(fifo_rden_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .bid_i(bid_i), .bresp_i(bresp_i),
    .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_w_q[$];
  logic [35:0] exp_aw_q[$];
  logic [1:0]  bresp_q[$];

  int          beats_left = 0;
  int          w_acc = 0;
  int          stall_at = -1;
  int          stall_cnt = 0;
  bit          b_pending = 0;
  bit          exp_done_next = 0;
  bit          exp_aw_next = 0;
  bit          check_start = 0;
  bit          cmd_fin = 0;
  bit          start_pend = 0;
  bit          in_rst = 0;
  bit          wready_rand = 0;
  bit          awready_rand = 0;
  bit          aw_hold = 0;
  logic [31:0] hold_addr;
  logic [3:0]  hold_len;
  logic [31:0] start_addr = '0;
  logic [15:0] start_len = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_bursts(input logic [31:0] addr, input logic [15:0] len);
    logic [31:0] a;
    int w, room, n;
    a = {addr[31:2], 2'b00};
    w = int'(len[15:2]);
    while (w > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      n = w;
      if (n > 16) n = 16;
      if (n > room) n = room;
      exp_aw_q.push_back({a, 4'(n - 1)});
      a = a + 32'(n * 4);
      w = w - n;
    end
  endfunction

  task automatic load_words(input int n);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      fifo_q.push_back(d);
      exp_w_q.push_back(d);
    end
  endtask

  // One clock: drive inputs on the falling edge, sample 1 ns later.
  task automatic step();
    logic [35:0] e;
    @(negedge clk);
    start_i    = start_pend;
    dst_addr_i = start_addr;
    byte_len_i = start_len;
    if (stall_at >= 0 && w_acc == stall_at) begin
      stall_cnt = 3;
      stall_at  = -1;
    end
    fifo_empty_i = (fifo_q.size() == 0) || (stall_cnt > 0);
    fifo_rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    wready_i  = in_rst ? 1'b0 : (wready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    awready_i = in_rst ? 1'b0 : (awready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    bvalid_i  = in_rst ? 1'b0 : b_pending;
    bresp_i   = (b_pending && bresp_q.size() != 0) ? bresp_q[0] : 2'b00;
    bid_i     = 4'd0;
    #1;
    if (check_start) begin
      chk("aw_after_start", awvalid_o, 1);
      chk("done_busy", done_o, 0);
      chk("err_clear", err_o, 0);
      check_start = 0;
    end
    if (start_pend) begin
      chk("done_idle", done_o, 1);
      start_pend = 0;
      if (start_len[15:2] != 14'd0) check_start = 1;
    end
    if (exp_aw_next) begin
      chk("aw_after_b", awvalid_o, 1);
      exp_aw_next = 0;
    end
    if (exp_done_next) begin
      chk("done_after_b", done_o, 1);
      exp_done_next = 0;
      cmd_fin = 1;
    end
    if (aw_hold) begin
      chk("aw_hold_valid", awvalid_o, 1);
      chk("aw_hold_addr", awaddr_o, hold_addr);
      chk("aw_hold_len", awlen_o, hold_len);
      aw_hold = 0;
    end
    chk("rden", fifo_rden_o, wvalid_o & wready_i);
    if (wvalid_o) chk("wvalid_fifo", fifo_empty_i, 0);
    if (beats_left == 0) chk("wvalid_no_burst", wvalid_o, 0);
    if (stall_cnt > 0) begin
      chk("wvalid_stall", wvalid_o, 0);
      stall_cnt--;
    end
    if (awvalid_o && !awready_i) begin
      aw_hold   = 1;
      hold_addr = awaddr_o;
      hold_len  = awlen_o;
    end
    if (awvalid_o && awready_i) begin
      if (exp_aw_q.size() == 0) chk("aw_unexpected", 1, 0);
      else begin
        e = exp_aw_q.pop_front();
        chk("awaddr", awaddr_o, e[35:4]);
        chk("awlen", awlen_o, e[3:0]);
        chk("aw_4k", 32'((32'(awaddr_o[11:0]) + (32'(awlen_o) + 1) * 4) <= 4096), 1);
        chk("awsize", awsize_o, 3'b010);
        chk("awburst", awburst_o, 2'b01);
        beats_left = int'(e[3:0]) + 1;
      end
    end else if (wvalid_o && wready_i) begin
      if (beats_left == 0) chk("w_unexpected", 1, 0);
      else begin
        if (exp_w_q.size() == 0) chk("w_extra", 1, 0);
        else chk("wdata", wdata_o, exp_w_q.pop_front());
        chk("wlast", wlast_o, beats_left == 1);
        chk("wstrb", wstrb_o, 4'hF);
        beats_left--;
        if (beats_left == 0) b_pending = 1;
      end
      w_acc++;
    end
    if (fifo_rden_o && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (bvalid_i && bready_o) begin
      b_pending = 0;
      if (bresp_q.size() != 0) void'(bresp_q.pop_front());
      if (exp_aw_q.size() == 0) exp_done_next = 1;
      else exp_aw_next = 1;
    end
  endtask

  task automatic flush();
    exp_aw_q.delete();
    bresp_q.delete();
    beats_left = 0; b_pending = 0; exp_done_next = 0; exp_aw_next = 0;
    check_start = 0; aw_hold = 0; stall_cnt = 0; stall_at = -1;
  endtask

  task automatic run_cmd(input logic [31:0] addr, input logic [15:0] len);
    load_words(int'(len[15:2]));
    push_bursts(addr, len);
    start_addr = addr;
    start_len  = len;
    start_pend = 1;
    cmd_fin    = 0;
    for (int i = 0; i < 2000 && !cmd_fin; i++) step();
    if (!cmd_fin) begin
      chk("timeout", 0, 1);
      flush();
      fifo_q.delete();
      exp_w_q.delete();
    end
    chk("aw_all_issued", exp_aw_q.size(), 0);
    chk("w_all_sent", exp_w_q.size(), 0);
  endtask

  task automatic chk_idle_outputs(input string pfx);
    chk({pfx, "_done"}, done_o, 1);
    chk({pfx, "_awvalid"}, awvalid_o, 0);
    chk({pfx, "_wvalid"}, wvalid_o, 0);
    chk({pfx, "_bready"}, bready_o, 0);
    chk({pfx, "_rden"}, fifo_rden_o, 0);
    chk({pfx, "_wlast"}, wlast_o, 0);
    chk({pfx, "_awaddr"}, awaddr_o, 0);
    chk({pfx, "_awlen"}, awlen_o, 0);
  endtask

  initial begin
    int target;
    rst = 1'b1;
    step();
    step();
    chk_idle_outputs("reset");
    chk("reset_err", err_o, 0);
    rst = 1'b0;

    run_cmd(32'h0000_1000, 16'd64);
    chk("err_ok1", err_o, 0);
    run_cmd(32'h0000_2000, 16'd72);
    run_cmd(32'h0000_0FF8, 16'd32);

    wready_rand  = 1;
    awready_rand = 1;
    stall_at     = w_acc + 5;
    run_cmd(32'h0000_3000, 16'd64);
    wready_rand  = 0;
    awready_rand = 0;
    stall_at     = -1;

    bresp_q.push_back(2'b10);
    bresp_q.push_back(2'b00);
    run_cmd(32'h0000_5000, 16'd72);
    chk("err_sticky", err_o, 1);

    start_addr = 32'h0000_9000;
    start_len  = 16'd0;
    start_pend = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("zero_len_awvalid", awvalid_o, 0);
      chk("zero_len_done", done_o, 1);
    end
    chk("zero_len_err_kept", err_o, 1);

    run_cmd(32'h0000_6000, 16'd16);
    chk("err_cleared", err_o, 0);

    // Reset in the middle of a 16-beat burst; FIFO words are left behind on
    // purpose to show the engine no longer presents or pops them.
    load_words(16);
    push_bursts(32'h0000_7000, 16'd64);
    start_addr = 32'h0000_7000;
    start_len  = 16'd64;
    start_pend = 1;
    target = w_acc + 4;
    for (int i = 0; i < 200 && w_acc < target; i++) step();
    if (w_acc < target) chk("timeout_rst", 0, 1);
    in_rst = 1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_rst = 0;
    flush();
    step();
    chk_idle_outputs("mid_rst");
    step();
    chk("mid_rst_rden2", fifo_rden_o, 0);
    fifo_q.delete();
    exp_w_q.delete();

    run_cmd(32'hFFFF_FFF0, 16'd32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmac_wr_engine.md
# dmac_wr_engine

Write-side engine of the DMAC: drains 32-bit words from the DMAC FIFO's show-ahead read port and issues AXI write bursts (AW/W/B) to the destination address. It sits between the FIFO read port and the AXI master write channels and is controlled by the DMAC register block through a start/done handshake. One command moves `byte_len_i` bytes as a sequence of INCR bursts that never cross a 4 KB boundary.

## Interface
- `MAX_BURST_LG2`, 4: maximum burst is 2^MAX_BURST_LG2 beats (16).
- `ID`, 4'd0: constant value driven on `awid_o` and `wid_o`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `start_i`  in  1  command strobe, sampled only in IDLE
- `dst_addr_i`  in  32  destination byte address, word aligned (bits [1:0] ignored and treated as 0)
- `byte_len_i`  in  16  transfer length in bytes; multiple of 4 (bits [1:0] ignored)
- `done_o`  out  1  high while IDLE
- `err_o`  out  1  sticky: set on any BRESP != OKAY; cleared on accepted start
- `fifo_empty_i`  in  1  FIFO empty
- `fifo_rdata_i`  in  32  FIFO head word, valid whenever `fifo_empty_i` = 0
- `fifo_rden_o`  out  1  pop the FIFO head
- `awid_o`  out  4  write address ID (= ID)
- `awaddr_o`  out  32  burst start address
- `awlen_o`  out  4  beats minus 1
- `awsize_o`  out  3  constant 3'b010
- `awburst_o`  out  2  constant 2'b01 (INCR)
- `awvalid_o`  out  1
- `awready_i`  in  1
- `wid_o`  out  4  write data ID (= ID)
- `wdata_o`  out  32  = `fifo_rdata_i`
- `wstrb_o`  out  4  constant 4'hF
- `wlast_o`  out  1
- `wvalid_o`  out  1
- `wready_i`  in  1
- `bid_i`  in  4  ignored
- `bresp_i`  in  2
- `bvalid_i`  in  1
- `bready_o`  out  1

## Operation
- Registers: `addr` (32), `remain` (16-bit word count), `beat_cnt` (4), `burst_len` (5), state.
- FSM states: IDLE, AW, W, B.
- IDLE:
  - `done_o` = 1.
  - `start_i` with `byte_len_i[15:2]` != 0: load `addr` = {dst_addr_i[31:2], 2'b00} and `remain` = byte_len_i[15:2], clear `err_o`, go to AW.
  - `start_i` with zero length: ignored; stay IDLE, `err_o` unchanged.
- AW:
  - `burst_len` = min(remain, 2^MAX_BURST_LG2, (4096 − addr[11:0])/4), computed combinationally from registered values.
  - `awvalid_o` = 1, `awaddr_o` = addr, `awlen_o` = burst_len − 1.
  - On `awready_i`: latch `beat_cnt` = burst_len − 1, then go to W.
- W:
  - `wvalid_o` = ~fifo_empty_i.
  - `fifo_rden_o` = wvalid_o & wready_i.
  - `wlast_o` = (beat_cnt == 0).
  - Each accepted beat decrements `beat_cnt`.
  - Accepted beat with `wlast_o` = 1: go to B.
- B:
  - `bready_o` = 1.
  - On `bvalid_i`: `err_o` |= (bresp_i != 2'b00); `addr` += burst_len×4; `remain` −= burst_len.
  - If the new `remain` is 0, go to IDLE; otherwise go to AW.
- Only one burst is outstanding at a time; AW for burst n+1 is issued only after B of burst n.
- `wdata_o` is valid only while `wvalid_o` = 1. `wvalid_o` may drop mid-burst when the FIFO runs empty; a word is never popped without a W handshake.

## Timing
- Reset values:
  - state IDLE, `done_o` = 1, `err_o` = 0.
  - `awvalid_o`, `wvalid_o`, `bready_o`, `fifo_rden_o`, `wlast_o` = 0.
  - `awaddr_o` = 0, `awlen_o` = 0.
- `start_i` at edge t: `awvalid_o` high in cycle t+1; `done_o` low from t+1.
- AW handshake at edge t: W beats may be accepted from cycle t+1.
- Zero-wait W: one beat per cycle; a burst of N beats takes N cycles with FIFO non-empty and `wready_i` high.
- Last B handshake at edge t: `done_o` = 1 in cycle t+1.
- `awvalid_o` stays high with `awaddr_o`/`awlen_o` stable until `awready_i`.
- `wvalid_o` depends only on FIFO state, never on `wready_i`.
- Address wrap: `addr` increments modulo 2^32; the 4 KB split keeps a single burst from wrapping.
- `rst` mid-transfer: next cycle returns to IDLE with all valids 0 and no further pops. The FIFO and the AXI slave are reset by the same `rst`.

## Test plan
- `dst_addr_i` = 0x1000, `byte_len_i` = 64, FIFO preloaded with 16 words, ready signals always high -> one AW (awaddr 0x1000, awlen 15), 16 W beats with wlast on beat 16, 16 pops, `done_o` high 1 cycle after B.
- `byte_len_i` = 72 at 0x2000 -> two bursts: awlen 15 at 0x2000, then awlen 1 at 0x2040.
- `dst_addr_i` = 0x0FF8, `byte_len_i` = 32 -> bursts at 0x0FF8 with awlen 1, then 0x1000 with awlen 5; no burst crosses 0x1000.
- FIFO empty for 3 cycles mid-burst and `wready_i` toggling -> `wvalid_o` low while empty, `fifo_rden_o` asserted only on W handshakes, word order preserved.
- BRESP = 2'b10 on the first of two bursts -> `err_o` = 1 and held through the end; the second burst still completes; the next start clears `err_o`.
- `rst` asserted during W of a 16-beat burst; `byte_len_i` = 0 start -> after reset: IDLE, `done_o` = 1, no valids. Zero-length start -> no AW, `done_o` stays 1.
